// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator dispatcher.
// Floors are numbered FLOOR_MIN..FLOOR_MAX. Request bit i stands for floor i+1.
package elevator_pkg;

  localparam int NUM_FLOORS = 9;

  typedef logic [3:0] floor_t;

  localparam floor_t FLOOR_MIN = 4'd1;
  localparam floor_t FLOOR_MAX = floor_t'(NUM_FLOORS);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN, HALT} state_t;

  // Returns the request bit position that belongs to floor f.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
    return NUM_FLOORS'(1) << (f - FLOOR_MIN);
  endfunction

endpackage

// File: rtl/elevator_dispatch_if.sv
// Bundle between the dispatcher and the car/request side.
// The master modport is the dispatcher and the slave modport is the car.
// Optional: FIRE_RECALL_EN adds the fire_recall input.
interface elevator_dispatch_if;
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] main_requests;
  logic                  move_up;
  logic                  move_down;
  logic                  stuck;
`ifdef FIRE_RECALL_EN
  logic                  fire_recall;
`endif
  floor_t                floor;
  floor_t                destination;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;

  modport master (
    input  main_requests, move_up, move_down, stuck,
`ifdef FIRE_RECALL_EN
    input  fire_recall,
`endif
    output floor, destination, door_open, pending, dir_up
  );

  modport slave (
    output main_requests, move_up, move_down, stuck,
`ifdef FIRE_RECALL_EN
    output fire_recall,
`endif
    input  floor, destination, door_open, pending, dir_up
  );

endinterface

// File: rtl/elevator_req_select.sv
// Finds the nearest pending floor for the collective (SCAN) policy.
// The search is one-sided: first strictly ahead in dir_up, then strictly behind.
module elevator_req_select
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                floor,
  input  logic                  dir_up,
  output logic                  found_same,
  output logic                  found_dir,
  output logic                  found_opp,
  output floor_t                target
);

  logic   any_up;
  logic   any_dn;
  floor_t near_up;
  floor_t near_dn;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    any_up  = 1'b0;
    any_dn  = 1'b0;
    near_up = floor;
    near_dn = floor;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (floor_t'(i + 1) > floor)) begin
        any_up  = 1'b1;
        near_up = floor_t'(i + 1);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (floor_t'(i + 1) < floor)) begin
        any_dn  = 1'b1;
        near_dn = floor_t'(i + 1);
      end
    end
  end

  // Pick the direction-relative result.
  always_comb begin
    found_same = |(pending & floor_onehot(floor));
    found_dir  = dir_up ? any_up : any_dn;
    found_opp  = dir_up ? any_dn : any_up;
    if (found_dir) target = dir_up ? near_up : near_dn;
    else           target = dir_up ? near_dn : near_up;
  end

endmodule

// File: rtl/elevator_dispatch.sv
// Elevator dispatcher: latches requests, tracks the car position from its
// move_up/move_down outputs, issues SCAN destinations and sequences the door.
// Optional: FIRE_RECALL_EN sends the car to floor 1 and holds the door open.
//
// state     | meaning
// IDLE      | car parked, choosing the next destination
// MOVING    | car travelling toward destination
// DOOR_OPEN | door open at a served floor
// HALT      | stuck alarm, dispatch frozen
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                clk,
  input  logic                reset,
  elevator_dispatch_if.master bus
);

  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);

  state_t                state_q, state_d;
  floor_t                floor_q, floor_d;
  floor_t                dest_q, dest_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  door_q, door_d;
  logic                  dir_up_q, dir_up_d;
  logic [TW-1:0]         travel_q, travel_d;
  logic [DW-1:0]         door_cnt_q, door_cnt_d;
  logic                  tdir_q, tdir_d;
`ifdef FIRE_RECALL_EN
  logic                  recall_q, recall_d;
`endif

  logic                  found_same, found_dir, found_opp;
  floor_t                target;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic                  step_up, step_dn;

  elevator_req_select u_sel (
    .pending    (pending_q),
    .floor      (floor_q),
    .dir_up     (dir_up_q),
    .found_same (found_same),
    .found_dir  (found_dir),
    .found_opp  (found_opp),
    .target     (target)
  );

  // Next-state logic for the dispatcher FSM, counters and request latch.
  always_comb begin
    clear_mask = (state_q == DOOR_OPEN) ? floor_onehot(floor_q) : '0;
    pending_d  = (pending_q | bus.main_requests) & ~clear_mask;
    state_d    = state_q;
    floor_d    = floor_q;
    dest_d     = dest_q;
    door_d     = door_q;
    dir_up_d   = dir_up_q;
    travel_d   = travel_q;
    door_cnt_d = door_cnt_q;
    tdir_d     = tdir_q;
    step_up    = bus.move_up && (dest_q > floor_q);
    step_dn    = bus.move_down && (dest_q < floor_q);
`ifdef FIRE_RECALL_EN
    recall_d   = bus.fire_recall;
`endif

    if (bus.stuck) begin
      state_d = HALT;
      dest_d  = floor_q;
    end else begin
      case (state_q)
        IDLE: begin
          door_d = 1'b0;
          if (found_same) begin
            state_d    = DOOR_OPEN;
            door_d     = 1'b1;
            door_cnt_d = '0;
            dest_d     = floor_q;
          end else if (found_dir || found_opp) begin
            state_d = MOVING;
            dest_d  = target;
            if (!found_dir) dir_up_d = ~dir_up_q;
          end else begin
            dest_d = floor_q;
          end
        end
        MOVING: begin
          if (floor_q == dest_q) begin
            state_d    = DOOR_OPEN;
            door_d     = 1'b1;
            door_cnt_d = '0;
          end else begin
            if (step_up || step_dn) begin
              tdir_d = step_up;
              // A reversal mid-transit discards the partial transit.
              if ((travel_q != '0) && (step_up != tdir_q)) begin
                travel_d = '0;
              end else if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
                travel_d = '0;
                if (step_up) floor_d = (floor_q == FLOOR_MAX) ? floor_q : floor_q + 4'd1;
                else         floor_d = (floor_q == FLOOR_MIN) ? floor_q : floor_q - 4'd1;
              end else begin
                travel_d = travel_q + TW'(1);
              end
            end
            // Pick up a pending floor strictly between the car and its target.
            if (found_dir && (dir_up_q ? (target < dest_q) : (target > dest_q)))
              dest_d = target;
          end
        end
        DOOR_OPEN: begin
          dest_d = floor_q;
`ifdef FIRE_RECALL_EN
          if (recall_q && !bus.fire_recall) begin
            state_d    = IDLE;
            door_d     = 1'b0;
            door_cnt_d = '0;
          end else
`endif
          if (|(bus.main_requests & floor_onehot(floor_q))) begin
            door_cnt_d = '0;
          end else if (door_cnt_q == DW'(DOOR_CYCLES - 1)) begin
            state_d    = IDLE;
            door_d     = 1'b0;
            door_cnt_d = '0;
          end else begin
            door_cnt_d = door_cnt_q + DW'(1);
          end
        end
        HALT: begin
          state_d    = IDLE;
          dest_d     = floor_q;
          travel_d   = '0;
          door_d     = 1'b0;
          door_cnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef FIRE_RECALL_EN
    // Recall overrides normal dispatch, but a stuck car still halts.
    if (bus.fire_recall && !bus.stuck) begin
      pending_d = '0;
      dest_d    = FLOOR_MIN;
      if (floor_q == FLOOR_MIN) begin
        state_d    = DOOR_OPEN;
        door_d     = 1'b1;
        door_cnt_d = '0;
      end else begin
        state_d = MOVING;
        door_d  = 1'b0;
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      floor_q    <= FLOOR_MIN;
      dest_q     <= FLOOR_MIN;
      pending_q  <= '0;
      door_q     <= 1'b0;
      dir_up_q   <= 1'b1;
      travel_q   <= '0;
      door_cnt_q <= '0;
      tdir_q     <= 1'b1;
`ifdef FIRE_RECALL_EN
      recall_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dest_q     <= dest_d;
      pending_q  <= pending_d;
      door_q     <= door_d;
      dir_up_q   <= dir_up_d;
      travel_q   <= travel_d;
      door_cnt_q <= door_cnt_d;
      tdir_q     <= tdir_d;
`ifdef FIRE_RECALL_EN
      recall_q   <= recall_d;
`endif
    end
  end

  assign bus.floor       = floor_q;
  assign bus.destination = dest_q;
  assign bus.door_open   = door_q;
  assign bus.pending     = pending_q;
  assign bus.dir_up      = dir_up_q;

endmodule

// File: tb/tb_elevator_dispatch.sv
// Directed bench for elevator_dispatch with a one-cycle-lag car model.
// The fire recall sequence is built only when FIRE_RECALL_EN is defined.
module tb_elevator_dispatch;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  elevator_dispatch_if bus ();

  elevator_dispatch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] req;
    logic [8:0] exp_pend;
    int         exp_dest;
    bit         exp_door;
    bit         exp_dir;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock, then the car registers its move outputs from the new destination.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.move_up   = (bus.destination > bus.floor);
    bus.move_down = (bus.destination < bus.floor);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.main_requests = '0;
    bus.stuck = 1'b0;
    bus.move_up = 1'b0;
    bus.move_down = 1'b0;
`ifdef FIRE_RECALL_EN
    bus.fire_recall = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [8:0] req);
    bus.main_requests = req;
    tick();
    bus.main_requests = '0;
  endtask

  task automatic wait_floor(input int f, input int maxc, output int n);
    n = 0;
    while (int'(bus.floor) != f && n < maxc) begin
      tick();
      n++;
    end
    if (int'(bus.floor) != f) n = -1;
  endtask

  task automatic wait_door(input bit v, input int maxc, output int n);
    n = 0;
    while (bus.door_open != v && n < maxc) begin
      tick();
      n++;
    end
    if (bus.door_open != v) n = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{9'h001, 9'h001, 1, 1'b1, 1'b1};
    vecs[1] = '{9'h008, 9'h008, 4, 1'b0, 1'b1};
    vecs[2] = '{9'h100, 9'h100, 9, 1'b0, 1'b1};
    vecs[3] = '{9'h0A4, 9'h0A4, 3, 1'b0, 1'b1};
    vecs[4] = '{9'h1FE, 9'h1FE, 2, 1'b0, 1'b1};
    vecs[5] = '{9'h000, 9'h000, 1, 1'b0, 1'b1};
    vecs[6] = '{9'h003, 9'h003, 1, 1'b1, 1'b1};

    // Reset values.
    do_reset();
    chk("rst floor", int'(bus.floor), 1);
    chk("rst dest", int'(bus.destination), 1);
    chk("rst pending", int'(bus.pending), 0);
    chk("rst door", int'(bus.door_open), 0);
    chk("rst dir_up", int'(bus.dir_up), 1);

    // Request latch and first IDLE decision from floor 1.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      pulse(vecs[i].req);
      chk($sformatf("vec%0d pending", i), int'(bus.pending), int'(vecs[i].exp_pend));
      tick();
      chk($sformatf("vec%0d dest", i), int'(bus.destination), vecs[i].exp_dest);
      chk($sformatf("vec%0d door", i), int'(bus.door_open), int'(vecs[i].exp_door));
      chk($sformatf("vec%0d dir_up", i), int'(bus.dir_up), int'(vecs[i].exp_dir));
    end

    // Full trip to floor 4 and door cycle.
    do_reset();
    pulse(9'h008);
    tick();
    chk("t1 dest", int'(bus.destination), 4);
    wait_floor(4, 100, n);
    chk("t1 travel cycles", n, 48);
    wait_door(1'b1, 5, n);
    chk("t1 door open delay", n, 1);
    wait_door(1'b0, 100, n);
    chk("t1 door open cycles", n, 32);
    chk("t1 pending cleared", int'(bus.pending), 0);

    // Retarget 7 -> 3 while passing floor 2.
    do_reset();
    pulse(9'h040);
    tick();
    chk("t2 dest7", int'(bus.destination), 7);
    wait_floor(2, 40, n);
    chk("t2 reach 2", n, 16);
    pulse(9'h004);
    tick();
    chk("t2 retarget", int'(bus.destination), 3);
    wait_floor(3, 40, n);
    chk("t2 reach 3", n, 14);
    wait_door(1'b1, 5, n);
    chk("t2 door at 3", n, 1);
    wait_door(1'b0, 100, n);
    chk("t2 door cycles", n, 32);
    tick();
    chk("t2 resume dest7", int'(bus.destination), 7);

    // SCAN from floor 5 with requests at 1 and 9.
    do_reset();
    pulse(9'h010);
    tick();
    wait_floor(5, 100, n);
    wait_door(1'b1, 5, n);
    wait_door(1'b0, 100, n);
    chk("t3 at 5", int'(bus.floor), 5);
    pulse(9'h101);
    tick();
    chk("t3 dest9", int'(bus.destination), 9);
    chk("t3 dir up", int'(bus.dir_up), 1);
    wait_floor(9, 100, n);
    chk("t3 reach 9", n, 64);
    wait_door(1'b1, 5, n);
    wait_door(1'b0, 100, n);
    chk("t3 door at 9", n, 32);
    tick();
    chk("t3 dest1", int'(bus.destination), 1);
    chk("t3 dir down", int'(bus.dir_up), 0);
    wait_floor(1, 200, n);
    chk("t3 reach 1", n, 128);
    wait_door(1'b1, 5, n);
    wait_door(1'b0, 100, n);
    chk("t3 pending empty", int'(bus.pending), 0);

    // Stuck mid-transit discards the partial transit.
    do_reset();
    pulse(9'h004);
    tick();
    wait_floor(2, 40, n);
    repeat (4) tick();
    bus.stuck = 1'b1;
    tick();
    chk("t4 halt dest", int'(bus.destination), 2);
    pulse(9'h100);
    chk("t4 halt latch", int'(bus.pending), 9'h104);
    repeat (5) tick();
    chk("t4 halt floor", int'(bus.floor), 2);
    chk("t4 halt dest hold", int'(bus.destination), 2);
    bus.stuck = 1'b0;
    tick();
    wait_floor(3, 40, n);
    chk("t4 restart transit", n, 17);

    // Current-floor request while the door is open restarts the door timer.
    do_reset();
    pulse(9'h001);
    tick();
    chk("t5 door open", int'(bus.door_open), 1);
    repeat (10) tick();
    pulse(9'h001);
    chk("t5 bit cleared", int'(bus.pending), 0);
    wait_door(1'b0, 100, n);
    chk("t5 door restart", n, 32);
    tick();
    chk("t5 stays closed", int'(bus.door_open), 0);
    chk("t5 pending empty", int'(bus.pending), 0);

`ifdef FIRE_RECALL_EN
    // Fire recall from floor 6 with pending upper floors.
    do_reset();
    pulse(9'h020);
    tick();
    wait_floor(6, 150, n);
    wait_door(1'b1, 5, n);
    wait_door(1'b0, 100, n);
    pulse(9'h1F0);
    chk("fr pending set", int'(bus.pending), 9'h1F0);
    bus.fire_recall = 1'b1;
    tick();
    chk("fr pending clr", int'(bus.pending), 0);
    chk("fr dest1", int'(bus.destination), 1);
    pulse(9'h002);
    chk("fr req ignored", int'(bus.pending), 0);
    wait_floor(1, 200, n);
    chk("fr reach 1", n, 79);
    wait_door(1'b1, 5, n);
    chk("fr door open", n, 1);
    repeat (100) tick();
    chk("fr door held", int'(bus.door_open), 1);
    bus.fire_recall = 1'b0;
    tick();
    chk("fr door closed", int'(bus.door_open), 0);
    tick();
    chk("fr pending after", int'(bus.pending), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
